// File: rtl/branch_predict_unit.sv
// Branch unit for the 5-stage OTTER pipeline.
// IF side: a direct-mapped BTB with a 2-bit counter per entry gives the predicted next PC.
// EX side: resolves the real outcome, flags mispredicts and trains the tables.
// An interrupt wins over a branch redirect and kills the EX instruction.
module branch_predict_unit #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 64,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch-side lookup
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    // execute-side resolution
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_br,
    input  logic            ex_is_jmp,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    // interrupt
    input  logic            intr,
    input  logic [XLEN-1:0] mtvec,
    // redirect
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            int_taken,
    // statistics
    output logic [31:0]     br_count,
    output logic [31:0]     miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    // BTB/BHT storage, one slot per index
    logic [ENTRIES-1:0]            valid;
    logic [ENTRIES-1:0]            jmp;
    logic [ENTRIES-1:0][TAG_W-1:0] tag;
    logic [ENTRIES-1:0][XLEN-1:0]  tgt;
    logic [ENTRIES-1:0][1:0]       ctr;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             act, ctl, miss, upd;
    logic [1:0]       ctr_cur, ctr_nxt;

    // Word-aligned PC bits below bit 2 and above the tag never reach the tables.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0], if_pc >> (TAG_HI + 1), ex_pc >> (TAG_HI + 1)};

    assign if_idx = if_pc[TAG_LO-1:2];
    assign if_tag = if_pc[TAG_HI:TAG_LO];
    assign ex_idx = ex_pc[TAG_LO-1:2];
    assign ex_tag = ex_pc[TAG_HI:TAG_LO];

    // Fetch lookup reads registered state only, so a same-cycle EX write is not seen.
    always_comb begin
        if_hit      = valid[if_idx] && (tag[if_idx] == if_tag);
        pred_taken  = if_hit && (jmp[if_idx] || ctr[if_idx][1]);
        pred_target = if_hit ? tgt[if_idx] : '0;
    end

    // Resolve the EX instruction; a taken prediction on a non-control op is an alias miss.
    always_comb begin
        act     = ex_is_jmp || (ex_is_br && ex_taken);
        ctl     = ex_is_br || ex_is_jmp;
        miss    = ex_valid && ((act != ex_pred_taken) || (act && (ex_target != ex_pred_target)));
        upd     = ex_valid && !intr;
        ex_hit  = valid[ex_idx] && (tag[ex_idx] == ex_tag);
        ctr_cur = ctr[ex_idx];
        if (!ex_hit)
            ctr_nxt = act ? 2'b10 : CTR_INIT;
        else if (act)
            ctr_nxt = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
        else
            ctr_nxt = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
    end

    // Redirect selection: interrupt first, then mispredict recovery.
    always_comb begin
        flush       = 1'b0;
        int_taken   = 1'b0;
        redirect_pc = '0;
        if (intr) begin
            flush       = 1'b1;
            int_taken   = 1'b1;
            redirect_pc = mtvec;
        end else if (miss) begin
            flush       = 1'b1;
            redirect_pc = act ? ex_target : ex_pc + XLEN'(4);
        end
    end

    // Table training: allocate/refresh on control ops, evict aliased entries otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            jmp   <= '0;
            tag   <= '0;
            tgt   <= '0;
            ctr   <= {ENTRIES{CTR_INIT}};
        end else if (upd) begin
            if (ctl) begin
                valid[ex_idx] <= 1'b1;
                tag[ex_idx]   <= ex_tag;
                jmp[ex_idx]   <= ex_is_jmp;
                ctr[ex_idx]   <= ctr_nxt;
                if (act)
                    tgt[ex_idx] <= ex_target;
            end else if (ex_pred_taken) begin
                valid[ex_idx] <= 1'b0;
            end
        end
    end

    // Resolved-op and mispredict counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (upd && ctl)
                br_count <= br_count + 32'd1;
            if (miss && !intr)
                miss_count <= miss_count + 32'd1;
        end
    end

endmodule
